// File: rtl/alu_muldiv_seq_pkg.sv
// ============================================================================
// mips_alu_pkg : shared ALU function codes, mul/div op codes, sequencer states
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_alu_pkg;

    typedef logic [5:0] alu_fun_t;
    typedef logic [1:0] md_op_t;

    localparam alu_fun_t ALU_ADD = 6'b000000;
    localparam alu_fun_t ALU_SUB = 6'b000001;
    localparam alu_fun_t ALU_AND = 6'b011000;
    localparam alu_fun_t ALU_OR  = 6'b011110;
    localparam alu_fun_t ALU_SLL = 6'b100000;
    localparam alu_fun_t ALU_EQ  = 6'b110011;

    localparam md_op_t MD_MULTU = 2'b00;
    localparam md_op_t MD_MULT  = 2'b01;
    localparam md_op_t MD_DIVU  = 2'b10;
    localparam md_op_t MD_DIV   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_t;

    function automatic logic md_is_div(input md_op_t op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input md_op_t op);
        return op[0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_muldiv_seq_if.sv
// ============================================================================
// alu_muldiv_seq_if : request/result bus plus the borrowed-ALU operand bus
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_muldiv_seq_if #(
    parameter int XLEN = 32
);
    import mips_alu_pkg::*;

    logic            start;
    md_op_t          op;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            div_by_zero;
    logic            alu_req;
    logic [XLEN-1:0] alu_inA;
    logic [XLEN-1:0] alu_inB;
    alu_fun_t        alu_fun;
    logic            alu_sign;
    logic [XLEN-1:0] alu_result;

    modport master (
        output start, op, src_a, src_b, alu_result,
        input  busy, done, hi, lo, div_by_zero,
        input  alu_req, alu_inA, alu_inB, alu_fun, alu_sign
    );

    modport slave (
        input  start, op, src_a, src_b, alu_result,
        output busy, done, hi, lo, div_by_zero,
        output alu_req, alu_inA, alu_inB, alu_fun, alu_sign
    );

endinterface

`default_nettype wire

// File: rtl/alu_muldiv_seq_fixup.sv
// ============================================================================
// muldiv_fixup : operand magnitude at start, result sign correction in FIX
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_fixup #(
    parameter int XLEN = 32
) (
    input  logic            signed_op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic [XLEN-1:0] abs_a,
    output logic [XLEN-1:0] abs_b,
    output logic            neg_a,
    output logic            neg_b,
    input  logic            is_div,
    input  logic            neg_res,
    input  logic            neg_rem,
    input  logic [XLEN-1:0] hi_in,
    input  logic [XLEN-1:0] lo_in,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out
);

    logic [2*XLEN-1:0] w_prod_neg;

    assign neg_a = signed_op & src_a[XLEN-1];
    assign neg_b = signed_op & src_b[XLEN-1];
    // -(-2^31) wraps back to 0x80000000, which is the correct unsigned magnitude
    assign abs_a = neg_a ? -src_a : src_a;
    assign abs_b = neg_b ? -src_b : src_b;

    assign w_prod_neg = -{hi_in, lo_in};

    always_comb begin
        hi_out = hi_in;
        lo_out = lo_in;
        if (is_div) begin
            if (neg_res) lo_out = -lo_in;
            if (neg_rem) hi_out = -hi_in;
        end else if (neg_res) begin
            {hi_out, lo_out} = w_prod_neg;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
// ============================================================================
// alu_muldiv_seq : MULT/MULTU/DIV/DIVU sequencer driving the shared ALU
// Optional: MULDIV_ZERO_SKIP_EN short-circuits zero-operand ops to DONE.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_muldiv_seq
    import mips_alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ITERS = 32
) (
    input  logic            clk,
    input  logic            reset,
    alu_muldiv_seq_if.slave bus
);

    localparam int            CW     = $clog2(ITERS);
    localparam logic [CW-1:0] C_LAST = CW'(ITERS - 1);

    md_state_t       r_state;
    md_state_t       w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic            r_is_div;
    logic            r_neg_res;
    logic            r_neg_rem;
    logic            r_dbz;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_opnd;

    logic            w_accept_start;
    logic            w_in_div;
    logic            w_in_signed;
    logic            w_div0;
    logic            w_zero_skip;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic            w_neg_a;
    logic            w_neg_b;
    logic [XLEN-1:0] w_fix_hi;
    logic [XLEN-1:0] w_fix_lo;
    logic [XLEN-1:0] w_rem_sh;
    logic [XLEN-1:0] w_alu_a;
    logic [XLEN-1:0] w_alu_b;
    logic            w_carry;
    logic            w_borrow;
    logic            w_accept;

    assign w_accept_start = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_in_div       = md_is_div(bus.op);
    assign w_in_signed    = md_is_signed(bus.op);
    assign w_div0         = w_in_div && (bus.src_b == '0);

`ifdef MULDIV_ZERO_SKIP_EN
    assign w_zero_skip = w_in_div ? ((bus.src_a == '0) && (bus.src_b != '0))
                                  : ((bus.src_a == '0) || (bus.src_b == '0));
`else
    assign w_zero_skip = 1'b0;
`endif

    muldiv_fixup #(
        .XLEN (XLEN)
    ) u_fixup (
        .signed_op (w_in_signed),
        .src_a     (bus.src_a),
        .src_b     (bus.src_b),
        .abs_a     (w_abs_a),
        .abs_b     (w_abs_b),
        .neg_a     (w_neg_a),
        .neg_b     (w_neg_b),
        .is_div    (r_is_div),
        .neg_res   (r_neg_res),
        .neg_rem   (r_neg_rem),
        .hi_in     (r_hi),
        .lo_in     (r_lo),
        .hi_out    (w_fix_hi),
        .lo_out    (w_fix_lo)
    );

    // Partial remainder shifted left by one; bit 32 of it lives in r_hi[31]
    assign w_rem_sh = {r_hi[XLEN-2:0], r_lo[XLEN-1]};

    assign w_carry  = (w_alu_a[XLEN-1] & w_alu_b[XLEN-1])
                    | ((w_alu_a[XLEN-1] | w_alu_b[XLEN-1]) & ~bus.alu_result[XLEN-1]);
    assign w_borrow = (~w_alu_a[XLEN-1] & w_alu_b[XLEN-1])
                    | ((~w_alu_a[XLEN-1] | w_alu_b[XLEN-1]) & bus.alu_result[XLEN-1]);
    assign w_accept = r_hi[XLEN-1] | ~w_borrow;

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_alu_a      = '0;
        w_alu_b      = '0;
        bus.alu_fun  = ALU_ADD;
        bus.alu_req  = 1'b0;
        bus.alu_sign = 1'b0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                bus.done = (r_state == ST_DONE);
                if (w_accept_start)
                    w_state_nxt = (w_div0 || w_zero_skip) ? ST_DONE : ST_ITER;
                else
                    w_state_nxt = ST_IDLE;
            end
            ST_ITER: begin
                bus.busy    = 1'b1;
                bus.alu_req = 1'b1;
                if (r_is_div) begin
                    bus.alu_fun = ALU_SUB;
                    w_alu_a     = w_rem_sh;
                    w_alu_b     = r_opnd;
                end else begin
                    w_alu_a = r_hi;
                    w_alu_b = r_lo[0] ? r_opnd : '0;
                end
                if (r_cnt == C_LAST) w_state_nxt = ST_FIX;
            end
            ST_FIX: begin
                bus.busy    = 1'b1;
                w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        bus.alu_inA = w_alu_a;
        bus.alu_inB = w_alu_b;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dbz     <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_opnd    <= '0;
        end else if (w_accept_start) begin
            r_cnt    <= '0;
            r_is_div <= w_in_div;
            r_hi     <= '0;
            r_dbz    <= 1'b0;
            if (w_div0) begin
                // No iterations follow, so the sign flags must not matter
                r_hi      <= bus.src_a;
                r_lo      <= '1;
                r_dbz     <= 1'b1;
                r_neg_res <= 1'b0;
                r_neg_rem <= 1'b0;
            end else if (w_zero_skip) begin
                r_lo      <= '0;
                r_neg_res <= 1'b0;
                r_neg_rem <= 1'b0;
            end else begin
                r_lo      <= w_in_div ? w_abs_a : w_abs_b;
                r_opnd    <= w_in_div ? w_abs_b : w_abs_a;
                r_neg_res <= w_neg_a ^ w_neg_b;
                r_neg_rem <= w_in_div & w_neg_a;
            end
        end else if (r_state == ST_ITER) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_is_div) begin
                r_hi <= w_accept ? bus.alu_result : w_rem_sh;
                r_lo <= {r_lo[XLEN-2:0], w_accept};
            end else begin
                {r_hi, r_lo} <= {w_carry, bus.alu_result, r_lo[XLEN-1:1]};
            end
        end else if (r_state == ST_FIX) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
        end
    end

    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;
    assign bus.div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
// ============================================================================
// tb_alu_muldiv_seq : directed vectors for alu_muldiv_seq with an ADD/SUB ALU model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_muldiv_seq;
    import mips_alu_pkg::*;

`ifdef MULDIV_ZERO_SKIP_EN
    localparam int ZS_LAT = 1;
    localparam int ZS_REQ = 0;
`else
    localparam int ZS_LAT = 34;
    localparam int ZS_REQ = 32;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   req_cyc = 0;
    int   done_cyc = 0;

    alu_muldiv_seq_if bus ();

    alu_muldiv_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.alu_result = (bus.alu_fun == 6'b000001) ? (bus.alu_inA - bus.alu_inB) :
                            (bus.alu_fun == 6'b000000) ? (bus.alu_inA + bus.alu_inB) : 32'h0;

    always @(negedge clk) begin
        if (bus.alu_req) req_cyc++;
        if (bus.done)    done_cyc++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " hi"}, bus.hi, 32'h0);
        chk({tag, " lo"}, bus.lo, 32'h0);
        chk({tag, " ctl"}, {bus.busy, bus.done, bus.div_by_zero, bus.alu_req, bus.alu_sign}, 5'b0);
        chk({tag, " alu"}, {bus.alu_inA[15:0], bus.alu_inB[15:0], bus.alu_fun}, 38'h0);
        chk({tag, " aluhi"}, {bus.alu_inA[31:16], bus.alu_inB[31:16]}, 32'h0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dbz, input int exp_lat, input int exp_req,
                          input int inject_at);
        int lat;
        int req0;
        int done0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        req0  = req_cyc;
        done0 = done_cyc;
        chk({tag, " busy1"}, bus.busy, (exp_lat > 1));
        lat = 0;
        for (int n = 1; n <= 60; n++) begin
            if (bus.done) begin
                lat = n;
                break;
            end
            if (n == inject_at) begin
                bus.start = 1'b1;
                bus.op    = MD_DIVU;
                bus.src_a = 32'h1;
                bus.src_b = 32'h0;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " hi"}, bus.hi, exp_hi);
        chk({tag, " lo"}, bus.lo, exp_lo);
        chk({tag, " dbz"}, bus.div_by_zero, exp_dbz);
        chk({tag, " busy"}, bus.busy, 1'b0);
        chk({tag, " req_cycles"}, req_cyc - req0, exp_req);
        @(posedge clk);
        #1;
        chk({tag, " done_pulse"}, done_cyc - done0, 1);
        chk({tag, " done_low"}, bus.done, 1'b0);
        chk({tag, " hi_held"}, bus.hi, exp_hi);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int done0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = MD_MULTU;
        bus.src_a = '0;
        bus.src_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_quiet("reset");
        reset = 1'b0;

        run_op("multu_ff", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34, 32, 0);
        run_op("mult_m7x3", MD_MULT, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34, 32, 0);
        run_op("mult_min2", MD_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b0, 34, 32, 0);
        run_op("divu_100_7", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, 32, 0);
        run_op("div_m100_7", MD_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0, 34, 32, 0);
        run_op("div_7_m2", MD_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 34, 32, 0);
        run_op("div_min_m1", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 34, 32, 0);
        run_op("divu_big", MD_DIVU, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 32'd1, 1'b0, 34, 32, 0);
        run_op("div_5_0", MD_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 1, 0, 0);
        run_op("multu_6x7", MD_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 34, 32, 0);
        run_op("busy_start", MD_MULTU, 32'd1000, 32'd1000, 32'd0, 32'h000F4240, 1'b0, 34, 32, 5);
        run_op("multu_0x123", MD_MULTU, 32'd0, 32'd123, 32'd0, 32'd0, 1'b0, ZS_LAT, ZS_REQ, 0);
        run_op("divu_0_5", MD_DIVU, 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, ZS_LAT, ZS_REQ, 0);

        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = MD_MULTU;
        bus.src_a = 32'hFFFFFFFF;
        bus.src_b = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("midrst req_before", bus.alu_req, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_quiet("midrst");
        reset = 1'b0;
        done0 = done_cyc;
        repeat (40) @(posedge clk);
        #1;
        chk("midrst no_done", done_cyc - done0, 0);
        chk("midrst idle", bus.busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle sequencer that runs MULT/MULTU/DIV/DIVU on the shared 32-bit ALU, one add or subtract per cycle.
- Sits beside the ALU in the execute stage and produces HI/LO.
- While it asserts alu_req, the top-level mux hands the ALU operand and function inputs to this block, and the pipeline stalls on busy.

Parameters:
- XLEN, 32, operand/result width (only 32 supported).
- ITERS, 32, shift-add / restoring-divide iteration count (= XLEN).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  operation request, sampled when not busy
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- src_a  in  32  multiplicand / dividend
- src_b  in  32  multiplier / divisor
- busy  out  1  operation in progress; ALU owned
- done  out  1  one-cycle pulse; hi/lo valid
- hi  out  32  product[63:32] / remainder
- lo  out  32  product[31:0] / quotient
- div_by_zero  out  1  sticky until next accepted start
- alu_req  out  1  ALU ownership request
- alu_inA  out  32  ALU operand A
- alu_inB  out  32  ALU operand B
- alu_fun  out  6  ALU function code
- alu_sign  out  1  ALU Sign input; always 0
- alu_result  in  32  combinational ALU result, same cycle

Behaviour:
- Reset: state IDLE, counter 0. hi, lo, busy, done, div_by_zero, alu_req, alu_inA, alu_inB, alu_fun and alu_sign are all 0. A reset mid-operation aborts with no done pulse.
- States: IDLE, ITER, FIX, DONE. alu_* outputs are 0 outside ITER.
- IDLE/DONE + start:
  - Latch op.
  - Signed ops: latch |src_a| and |src_b|, and record the sign of the result and remainder.
  - Set hi=0 and clear div_by_zero. Go to ITER with cnt=0; busy=1 from the next cycle.
- start while busy is ignored.
- Division with divisor 0: set hi=src_a, lo=32'hFFFFFFFF and div_by_zero=1, then go directly to DONE. No ITER, no sign fixup.
- ITER (ITERS cycles, alu_req=1), multiply:
  - lo holds |multiplier|. alu_fun=000000 (ADD), alu_inA=hi, alu_inB = lo[0] ? mcand : 0.
  - Carry = (A31&B31)|((A31|B31)&~R31).
  - {hi,lo} <= {carry, alu_result, lo} >> 1.
- ITER, divide:
  - lo holds |dividend|. Form R = {hi[30:0], lo[31]}; alu_fun=000001 (SUB), alu_inA=R, alu_inB=|divisor|.
  - Borrow = (~A31&B31)|((~A31|B31)&R31). Accept = hi[31] | ~borrow.
  - hi <= accept ? alu_result : R; lo <= {lo[30:0], accept}.
- ITER exit: cnt increments each cycle; leave ITER after cnt==ITERS-1.
- FIX (1 cycle, busy=1, no ALU use):
  - MULT: negate 64-bit {hi,lo} if the operand signs differ.
  - DIV: negate lo if the signs differ; negate hi if the dividend was negative.
  - Unsigned ops pass through unchanged.
- DONE: done=1 for exactly one cycle, busy=0, hi/lo held until the next start.
- Latency: start at edge k gives done high in cycle k+34.
- DIV 0x80000000 / -1 gives lo=0x80000000, hi=0; no trap.

Optional Feature:
- MULDIV_ZERO_SKIP_EN defined:
  - Multiply with src_a==0 or src_b==0 goes IDLE -> DONE in 1 cycle with hi=lo=0.
  - Divide with a zero dividend and nonzero divisor goes IDLE -> DONE in 1 cycle with hi=lo=0.
  - alu_req is never raised on these paths.
- Undefined: these operands take the full 34-cycle path with identical results.

Decomposition:
- Package mips_alu_pkg holds:
  - ALUFun constants: ALU_ADD=6'b000000, ALU_SUB=6'b000001, ALU_AND=6'b011000, ALU_OR=6'b011110, ALU_SLL=6'b100000, ALU_EQ=6'b110011.
  - MD_MULTU/MD_MULT/MD_DIVU/MD_DIV op codes.
  - The state enum.
- Sub-module muldiv_fixup: combinational 32-bit abs and 64-bit / split conditional negation, used at start and in FIX.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done in cycle k+34; alu_req high for exactly 32 cycles.
- MULT -7 × 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULT 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0.
- DIVU 100 / 7 -> lo=14, hi=2; DIV -100 / 7 -> lo=-14 (0xFFFFFFF2), hi=-2 (0xFFFFFFFE); DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- DIV 5 / 0 -> done the cycle after start, div_by_zero=1, hi=5, lo=0xFFFFFFFF; the next valid start clears div_by_zero.
- Reset at ITER cnt=10 -> next cycle all outputs 0, no done pulse. start during busy is ignored and the running result is unchanged.
- With MULDIV_ZERO_SKIP_EN: MULTU 0 × 123 -> done 1 cycle after start, hi=lo=0, alu_req never high. Without the macro: same result at k+34.
